// File: rtl/data_stack_pkg.sv
// Shared constants for the operand stack: op codes, FSM states, op decode.
package data_stack_pkg;

  localparam logic [2:0] STK_NOP  = 3'b000;
  localparam logic [2:0] STK_PUSH = 3'b001;
  localparam logic [2:0] STK_POP  = 3'b010;
  localparam logic [2:0] STK_DUP  = 3'b011;
  localparam logic [2:0] STK_SWAP = 3'b100;
  localparam logic [2:0] STK_CLR  = 3'b101;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWAP2 = 1'b1;

  // Folds unknown codes to NOP, then lets a PC pop fill an otherwise idle slot.
  function automatic logic [2:0] stk_decode(input logic [2:0] op, input logic pop);
    logic [2:0] e;
    e = (op > STK_CLR) ? STK_NOP : op;
    if (e == STK_NOP && pop == 1'b1) e = STK_POP;
    return e;
  endfunction

endpackage

// File: rtl/data_stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module stack_ram #(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_a_i,
  input  logic [AW-1:0]       raddr_b_i,
  output logic [DATA_LEN-1:0] rdata_a_o,
  output logic [DATA_LEN-1:0] rdata_b_o
);

  logic [DATA_LEN-1:0] mem_q [DEPTH];

  // Single write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/data_stack.sv
// LIFO operand stack: pointer, SWAP state machine, sticky error flags.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 stk_op,
  input  logic [DATA_LEN-1:0]        stk_data_in,
  input  logic                       stk_pop,
  output logic [DATA_LEN-1:0]        stk_data_out,
  output logic [$clog2(DEPTH):0]     stk_count,
  output logic                       stk_empty,
  output logic                       stk_full,
  output logic                       stk_ovf,
  output logic                       stk_unf,
  output logic                       stk_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]       count_q, count_d;
  logic [DATA_LEN-1:0] top_q, top_d, save_q, save_d;
  logic                ovf_q, ovf_d, unf_q, unf_d, ack_q, ack_d;
  logic [0:0]          state_q, state_d;
  logic                we;
  logic [AW-1:0]       waddr, ra1, ra2;
  logic [DATA_LEN-1:0] wdata, rd1, rd2;
  logic [2:0]          eop;
  logic                full, empty;

  assign ra1   = AW'(count_q - CW'(1));
  assign ra2   = AW'(count_q - CW'(2));
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign eop   = stk_decode(stk_op, stk_pop);

  stack_ram #(.DATA_LEN(DATA_LEN), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk       (clk),
    .we_i      (we & ~rst),   // a reset cycle discards its op, RAM write included
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (ra1),
    .raddr_b_i (ra2),
    .rdata_a_o (rd1),
    .rdata_b_o (rd2)
  );

  // Next-state: decode the effective op against the current fill level.
  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    save_d  = save_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ack_d   = 1'b0;
    state_d = state_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];
    wdata   = stk_data_in;
    if (state_q == S_SWAP2) begin
      // Second half of SWAP: old top lands in the lower slot; inputs ignored.
      we      = 1'b1;
      waddr   = ra2;
      wdata   = save_q;
      ack_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (eop)
        STK_PUSH, STK_DUP: begin
          if (eop == STK_DUP && empty) unf_d = 1'b1;
          else if (full) ovf_d = 1'b1;
          else begin
            we      = 1'b1;
            wdata   = (eop == STK_DUP) ? rd1 : stk_data_in;
            top_d   = wdata;
            count_d = count_q + CW'(1);
            ack_d   = 1'b1;
          end
        end
        STK_POP: begin
          if (empty) unf_d = 1'b1;
          else begin
            top_d   = (count_q == CW'(1)) ? '0 : rd2;
            count_d = count_q - CW'(1);
            ack_d   = 1'b1;
          end
        end
        STK_SWAP: begin
          if (count_q < CW'(2)) unf_d = 1'b1;
          else begin
            we      = 1'b1;
            waddr   = ra1;
            wdata   = rd2;
            top_d   = rd2;
            save_d  = rd1;
            state_d = S_SWAP2;
          end
        end
        STK_CLR: begin
          count_d = '0;
          top_d   = '0;
          ack_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      top_q   <= '0;
      save_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ack_q   <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      save_q  <= save_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ack_q   <= ack_d;
      state_q <= state_d;
    end
  end

  assign stk_data_out = top_q;
  assign stk_count    = count_q;
  assign stk_empty    = empty;
  assign stk_full     = full;
  assign stk_ovf      = ovf_q;
  assign stk_unf      = unf_q;
  assign stk_ack      = ack_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack against a queue-based stack model.
module tb_data_stack;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] stk_op;
  logic [7:0] stk_data_in;
  logic       stk_pop;
  logic [7:0] stk_data_out;
  logic [4:0] stk_count;
  logic       stk_empty, stk_full, stk_ovf, stk_unf, stk_ack;

  data_stack #(.DATA_LEN(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .stk_op(stk_op), .stk_data_in(stk_data_in),
    .stk_pop(stk_pop), .stk_data_out(stk_data_out), .stk_count(stk_count),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_ovf(stk_ovf),
    .stk_unf(stk_unf), .stk_ack(stk_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: a queue whose back is the top of stack.
  logic [7:0] m[$];
  bit m_ovf, m_unf;

  wire [16:0] dut_vec = {stk_count, stk_data_out, stk_ovf, stk_unf, stk_empty, stk_full};

  function automatic logic [16:0] exp_vec();
    logic [7:0] t;
    t = (m.size() == 0) ? 8'h00 : m[m.size()-1];
    return {5'(m.size()), t, m_ovf, m_unf, m.size() == 0, m.size() == 16};
  endfunction

  task automatic model_reset();
    m.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_op(input logic [2:0] op, input logic p, input logic [7:0] d,
                          output bit acc, output bit swp);
    logic [2:0] e;
    logic [7:0] t;
    int n;
    acc = 0; swp = 0;
    n = m.size();
    e = (op > 3'd5) ? 3'd0 : op;
    if (e == 3'd0 && p === 1'b1) e = 3'd2;
    case (e)
      3'd1: if (n == 16) m_ovf = 1; else begin m.push_back(d); acc = 1; end
      3'd2: if (n == 0) m_unf = 1; else begin void'(m.pop_back()); acc = 1; end
      3'd3: if (n == 0) m_unf = 1; else if (n == 16) m_ovf = 1;
            else begin m.push_back(m[n-1]); acc = 1; end
      3'd4: if (n < 2) m_unf = 1;
            else begin t = m[n-1]; m[n-1] = m[n-2]; m[n-2] = t; acc = 1; swp = 1; end
      3'd5: begin m.delete(); acc = 1; end
      default: ;
    endcase
  endtask

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic [2:0] op, input logic [7:0] d, input logic p, input logic r);
    stk_op = op; stk_data_in = d; stk_pop = p; rst = r;
    @(posedge clk); #1;
    stk_op = 3'd0; stk_pop = 1'b0; rst = 1'b0;
  endtask

  // Step the DUT and the model together; for SWAP also run the second cycle
  // and check the ack lands only after it.
  task automatic do_op(input logic [2:0] op, input logic [7:0] d, input logic p, output bit acc);
    bit swp;
    model_op(op, p, d, acc, swp);
    step(op, d, p, 1'b0);
    if (swp) begin
      checks++;
      if (stk_ack !== 1'b0) begin failures++; $display("FAIL swap_early_ack got=%b want=0", stk_ack); end
      step(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset();
    step(3'd0, 8'h00, 1'b0, 1'b1);
    model_reset();
    checks++;
    if ({dut_vec, stk_ack} !== {17'h0_00_02 << 0 | 17'b0_00000000_0010, 1'b0}) begin
      failures++; $display("FAIL reset_state got=%h ack=%b", dut_vec, stk_ack);
    end
  endtask

  task automatic test_push_pop();
    bit acc;
    do_op(3'd1, 8'h0A, 1'b0, acc);
    checks++;
    if (stk_ack !== 1'b1) begin failures++; $display("FAIL push1_ack got=%b want=1", stk_ack); end
    do_op(3'd1, 8'h14, 1'b0, acc);
    checks++;
    if ({stk_data_out, stk_count, stk_ack} !== {8'h14, 5'd2, 1'b1}) begin
      failures++; $display("FAIL push2 got top=%h cnt=%0d ack=%b want 14/2/1", stk_data_out, stk_count, stk_ack);
    end
    do_op(3'd0, 8'h00, 1'b1, acc);
    checks++;
    if ({stk_data_out, stk_count, stk_ack} !== {8'h0A, 5'd1, 1'b1}) begin
      failures++; $display("FAIL pc_pop got top=%h cnt=%0d ack=%b want 0a/1/1", stk_data_out, stk_count, stk_ack);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin failures++; $display("FAIL push_pop_state got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_overflow();
    bit acc;
    test_reset();
    for (int i = 0; i < 16; i++) do_op(3'd1, 8'(i), 1'b0, acc);
    checks++;
    if ({stk_full, stk_data_out, stk_count} !== {1'b1, 8'd15, 5'd16}) begin
      failures++; $display("FAIL fill got full=%b top=%h cnt=%0d", stk_full, stk_data_out, stk_count);
    end
    do_op(3'd1, 8'hFF, 1'b0, acc);
    checks++;
    if ({stk_ovf, stk_data_out, stk_count, stk_ack} !== {1'b1, 8'd15, 5'd16, 1'b0}) begin
      failures++; $display("FAIL overflow got ovf=%b top=%h cnt=%0d ack=%b", stk_ovf, stk_data_out, stk_count, stk_ack);
    end
  endtask

  task automatic test_underflow();
    bit acc;
    test_reset();
    do_op(3'd2, 8'h00, 1'b0, acc);
    checks++;
    if ({stk_unf, stk_count, stk_data_out, stk_ack} !== {1'b1, 5'd0, 8'h00, 1'b0}) begin
      failures++; $display("FAIL underflow got unf=%b cnt=%0d top=%h ack=%b", stk_unf, stk_count, stk_data_out, stk_ack);
    end
    do_op(3'd1, 8'h05, 1'b0, acc);
    checks++;
    if ({stk_data_out, stk_unf, stk_ack} !== {8'h05, 1'b1, 1'b1}) begin
      failures++; $display("FAIL push_after_unf got top=%h unf=%b ack=%b", stk_data_out, stk_unf, stk_ack);
    end
  endtask

  task automatic test_dup_swap();
    bit acc;
    test_reset();
    do_op(3'd1, 8'd3, 1'b0, acc);
    do_op(3'd1, 8'd7, 1'b0, acc);
    do_op(3'd3, 8'h00, 1'b0, acc);
    checks++;
    if ({stk_data_out, stk_count} !== {8'd7, 5'd3}) begin
      failures++; $display("FAIL dup got top=%h cnt=%0d want 07/3", stk_data_out, stk_count);
    end
    do_op(3'd4, 8'h00, 1'b0, acc);
    checks++;
    if ({stk_data_out, stk_ack} !== {8'd7, 1'b1}) begin
      failures++; $display("FAIL swap_equal got top=%h ack=%b", stk_data_out, stk_ack);
    end
    do_op(3'd1, 8'd9, 1'b0, acc);
    do_op(3'd4, 8'h00, 1'b0, acc);
    checks++;
    if ({stk_data_out, stk_ack, stk_count} !== {8'd7, 1'b1, 5'd4}) begin
      failures++; $display("FAIL swap got top=%h ack=%b cnt=%0d want 07/1/4", stk_data_out, stk_ack, stk_count);
    end
    do_op(3'd2, 8'h00, 1'b0, acc);
    checks++;
    if (stk_data_out !== 8'd9) begin failures++; $display("FAIL pop_after_swap got=%h want=09", stk_data_out); end
    checks++;
    if (dut_vec !== exp_vec()) begin failures++; $display("FAIL dup_swap_state got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_conflict();
    bit acc;
    logic [4:0] c0;
    c0 = stk_count;
    do_op(3'd1, 8'h21, 1'b1, acc);
    checks++;
    if ({stk_data_out, stk_count, stk_ack} !== {8'h21, c0 + 5'd1, 1'b1}) begin
      failures++; $display("FAIL push_vs_pop got top=%h cnt=%0d ack=%b", stk_data_out, stk_count, stk_ack);
    end
    do_op(3'd0, 8'h00, 1'bz, acc);
    checks++;
    if ({stk_data_out, stk_count, stk_ack} !== {8'h21, c0 + 5'd1, 1'b0}) begin
      failures++; $display("FAIL pop_z got top=%h cnt=%0d ack=%b", stk_data_out, stk_count, stk_ack);
    end
  endtask

  task automatic test_reset_mid_swap();
    bit acc, swp;
    test_reset();
    do_op(3'd2, 8'h00, 1'b0, acc);            // sets unf
    do_op(3'd1, 8'd1, 1'b0, acc);
    do_op(3'd1, 8'd2, 1'b0, acc);
    step(3'd4, 8'h00, 1'b0, 1'b0);            // enters SWAP2
    step(3'd0, 8'h00, 1'b0, 1'b1);            // reset during SWAP2
    model_reset();
    checks++;
    if ({dut_vec, stk_ack} !== {exp_vec(), 1'b0}) begin
      failures++; $display("FAIL reset_mid_swap got=%h ack=%b want=%h", dut_vec, stk_ack, exp_vec());
    end
    do_op(3'd1, 8'h44, 1'b0, acc);
    checks++;
    if ({stk_ack, stk_data_out} !== {1'b1, 8'h44}) begin
      failures++; $display("FAIL idle_after_reset got ack=%b top=%h", stk_ack, stk_data_out);
    end
    do_op(3'd2, 8'h00, 1'b0, acc);
    do_op(3'd2, 8'h00, 1'b0, acc);            // underflow again
    do_op(3'd1, 8'd1, 1'b0, acc);
    do_op(3'd1, 8'd2, 1'b0, acc);
    model_op(3'd5, 1'b0, 8'h00, acc, swp);
    step(3'd5, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({stk_count, stk_data_out, stk_unf, stk_ack} !== {5'd0, 8'h00, 1'b1, 1'b1}) begin
      failures++; $display("FAIL clr got cnt=%0d top=%h unf=%b ack=%b", stk_count, stk_data_out, stk_unf, stk_ack);
    end
  endtask

  task automatic test_random();
    bit acc;
    logic [2:0] op;
    int r;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 31);
      if (r < 14) op = 3'd1; else if (r < 20) op = 3'd2; else if (r < 23) op = 3'd3;
      else if (r < 27) op = 3'd4; else if (r < 29) op = 3'd0; else if (r == 29) op = 3'd7;
      else if (r == 30) op = 3'd6; else op = 3'd5;
      do_op(op, 8'($urandom), ($urandom_range(0, 3) == 0), acc);
      checks++;
      if ({dut_vec, stk_ack} !== {exp_vec(), acc}) begin
        failures++;
        $display("FAIL random[%0d] op=%0d got=%h ack=%b want=%h ack=%b", i, op, dut_vec, stk_ack, exp_vec(), acc);
      end
    end
  endtask

  initial begin
    stk_op = 3'd0; stk_data_in = 8'h00; stk_pop = 1'b0; rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_dup_swap();
    test_conflict();
    test_reset_mid_swap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
